debug_cmd_controller: RTL and testbench

Command sequencer for the MIPS debug unit. Sits between the UART receiver and the processor core. Interprets command bytes from the host, assembles big-endian instruction words into instruction memory, and gates the pipeline in continuous or single-step mode. After each run or step it requests a register/memory dump from the transmit path.

---
 rtl/debug_cmd_controller.sv | 109 ++++++++++
 tb/tb_debug_cmd_controller.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_cmd_controller.sv
// Debug command sequencer: decodes host bytes, assembles big-endian words into
// instruction memory, and gates the pipeline in run or single-step mode.
module debug_cmd_controller #(
    parameter int          ADDR_W     = 8,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
    parameter logic [7:0]  CMD_LOAD   = 8'h01,
    parameter logic [7:0]  CMD_STEP   = 8'h02,
    parameter logic [7:0]  CMD_CONT   = 8'h04
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_done,
    input  logic              i_cpu_halted,
    input  logic              i_dump_done,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_data,
    output logic              o_cpu_en,
    output logic              o_dump_req,
    output logic              o_err,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_STEP = 3'd3,
        S_DUMP = 3'd4
    } state_t;

    state_t      state, state_nx;
    logic        cpu_en_nx, dump_req_nx;
    logic        load_byte, load_cmd, write_last;
    logic [1:0]  byte_cnt;
    logic [31:0] asm_word;

    assign o_state   = state;
    assign load_byte = (state == S_LOAD) && i_rx_done;
    assign load_cmd  = (state == S_IDLE) && i_rx_done && (i_rx_data == CMD_LOAD);
    // Load ends on the write cycle itself, once the written word's fate is known.
    assign write_last = o_imem_we && ((o_imem_data == HALT_INSTR) || (o_imem_addr == '1));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (i_rx_done) begin
                    if (i_rx_data == CMD_LOAD)      state_nx = S_LOAD;
                    else if (i_rx_data == CMD_CONT) state_nx = S_RUN;
                    else if (i_rx_data == CMD_STEP) state_nx = S_STEP;
                end
            end
            S_LOAD: if (write_last) state_nx = S_IDLE;
            S_RUN:  if (i_cpu_halted) state_nx = S_DUMP;
            S_STEP: state_nx = S_DUMP;
            S_DUMP: if (i_dump_done) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        cpu_en_nx   = (state_nx == S_RUN) || (state_nx == S_STEP);
        dump_req_nx = (state_nx == S_DUMP) && (state != S_DUMP);
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            o_cpu_en   <= 1'b0;
            o_dump_req <= 1'b0;
        end else begin
            state      <= state_nx;
            o_cpu_en   <= cpu_en_nx;
            o_dump_req <= dump_req_nx;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            byte_cnt    <= '0;
            asm_word    <= '0;
            o_imem_we   <= 1'b0;
            o_imem_data <= '0;
            o_imem_addr <= '0;
            o_err       <= 1'b0;
        end else begin
            o_imem_we <= load_byte && (byte_cnt == 2'd3);
            if (load_byte) begin
                asm_word <= {asm_word[23:0], i_rx_data};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) o_imem_data <= {asm_word[23:0], i_rx_data};
            end
            if (load_cmd) begin
                byte_cnt    <= '0;
                o_imem_addr <= '0;
                o_err       <= 1'b0;
            end else if (o_imem_we && (state == S_LOAD)) begin
                if (o_imem_data == HALT_INSTR) begin
                    o_imem_addr <= '0;
                end else if (o_imem_addr == '1) begin
                    o_err       <= 1'b1;
                    o_imem_addr <= '0;
                end else begin
                    o_imem_addr <= o_imem_addr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_debug_cmd_controller.sv
// Scoreboard bench: default-width DUT for load/run/step, ADDR_W=2 DUT for overflow.
module tb_debug_cmd_controller;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halted = 1'b0;
    logic        dump_done = 1'b0;
    logic [7:0]  rxd [2];
    logic        rxv [2];
    logic        we [2];
    logic [31:0] idata [2];
    logic [7:0]  addr [2];
    logic        cpu_en [2];
    logic        dreq [2];
    logic        err [2];
    logic [2:0]  st [2];
    logic [1:0]  addr_small;

    int          tests = 0;
    int          fails = 0;
    wr_t         wq0[$];
    wr_t         wq1[$];
    int          dq[$];
    int          run_len = 0;

    always #5 clk = ~clk;

    assign addr[1] = {6'b0, addr_small};

    debug_cmd_controller dut0 (
        .clk(clk), .i_rst_n(rst_n), .i_rx_data(rxd[0]), .i_rx_done(rxv[0]),
        .i_cpu_halted(halted), .i_dump_done(dump_done),
        .o_imem_we(we[0]), .o_imem_addr(addr[0]), .o_imem_data(idata[0]),
        .o_cpu_en(cpu_en[0]), .o_dump_req(dreq[0]), .o_err(err[0]), .o_state(st[0])
    );

    debug_cmd_controller #(.ADDR_W(2)) dut1 (
        .clk(clk), .i_rst_n(rst_n), .i_rx_data(rxd[1]), .i_rx_done(rxv[1]),
        .i_cpu_halted(halted), .i_dump_done(dump_done),
        .o_imem_we(we[1]), .o_imem_addr(addr_small), .o_imem_data(idata[1]),
        .o_cpu_en(cpu_en[1]), .o_dump_req(dreq[1]), .o_err(err[1]), .o_state(st[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitors: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        wr_t e;
        if (we[0]) begin
            if (wq0.size() == 0) begin
                tests++; fails++;
                $display("FAIL dut0 unexpected write: addr %h data %h", addr[0], idata[0]);
            end else begin
                e = wq0.pop_front();
                check("dut0 write addr", {24'h0, addr[0]}, {24'h0, e.a});
                check("dut0 write data", idata[0], e.d);
            end
        end
        if (we[1]) begin
            if (wq1.size() == 0) begin
                tests++; fails++;
                $display("FAIL dut1 unexpected write: addr %h data %h", addr[1], idata[1]);
            end else begin
                e = wq1.pop_front();
                check("dut1 write addr", {24'h0, addr[1]}, {24'h0, e.a});
                check("dut1 write data", idata[1], e.d);
            end
        end
    end

    // Dump monitor: each dump request must follow a cpu_en burst of the queued length.
    always @(negedge clk) begin
        if (cpu_en[0]) begin
            run_len++;
            if (dreq[0]) check("dump_req while cpu_en", 32'd1, 32'd0);
        end else begin
            if (dreq[0]) begin
                if (dq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected dump_req: burst %0d", run_len);
                end else begin
                    check("cpu_en burst before dump", run_len, dq.pop_front());
                end
            end
            run_len = 0;
        end
        if (dreq[1] || cpu_en[1]) check("dut1 must not run", 32'd1, 32'd0);
    end

    task automatic send_byte(input int d, input logic [7:0] b);
        @(posedge clk); #1;
        rxd[d] = b; rxv[d] = 1'b1;
        @(posedge clk); #1;
        rxv[d] = 1'b0;
    endtask

    task automatic send_word(input int d, input logic [31:0] w);
        for (int unsigned i = 0; i < 4; i++) send_byte(d, w[31 - 8*i -: 8]);
    endtask

    task automatic send_stream3(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        logic [31:0] ws [3];
        logic [31:0] w;
        ws[0] = w0; ws[1] = w1; ws[2] = w2;
        for (int unsigned k = 0; k < 3; k++) begin
            w = ws[k];
            for (int unsigned i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                rxd[0] = w[31 - 8*i -: 8]; rxv[0] = 1'b1;
            end
        end
        @(posedge clk); #1;
        rxv[0] = 1'b0;
    endtask

    task automatic wait_state(input int d, input logic [2:0] s, input string name);
        int unsigned n;
        n = 0;
        while (st[d] !== s && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, {29'h0, st[d]}, {29'h0, s});
    endtask

    task automatic pulse_dump_done;
        @(posedge clk); #1; dump_done = 1'b1;
        @(posedge clk); #1; dump_done = 1'b0;
    endtask

    task automatic check_reset_outputs(input int d);
        check("rst we", {31'h0, we[d]}, 32'h0);
        check("rst addr", {24'h0, addr[d]}, 32'h0);
        check("rst data", idata[d], 32'h0);
        check("rst cpu_en", {31'h0, cpu_en[d]}, 32'h0);
        check("rst dump_req", {31'h0, dreq[d]}, 32'h0);
        check("rst err", {31'h0, err[d]}, 32'h0);
        check("rst state", {29'h0, st[d]}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rxd[0] = '0; rxd[1] = '0; rxv[0] = 1'b0; rxv[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs(0);
        rst_n = 1'b1;

        // Load program ending in halt word
        wq0.push_back('{8'd0, 32'h2001_000F});
        wq0.push_back('{8'd1, 32'h2002_0008});
        wq0.push_back('{8'd2, 32'h0022_1821});
        wq0.push_back('{8'd3, 32'hFFFF_FFFF});
        send_byte(0, 8'h01);
        check("load entry state", {29'h0, st[0]}, 32'd1);
        send_word(0, 32'h2001_000F);
        send_word(0, 32'h2002_0008);
        send_word(0, 32'h0022_1821);
        send_word(0, 32'hFFFF_FFFF);
        repeat (3) @(posedge clk);
        #1;
        check("load done state", {29'h0, st[0]}, 32'd0);
        check("load done addr", {24'h0, addr[0]}, 32'h0);
        check("load done err", {31'h0, err[0]}, 32'h0);

        // Continuous run, halt on the 20th enabled cycle
        dq.push_back(20);
        send_byte(0, 8'h04);
        check("run entry cpu_en", {31'h0, cpu_en[0]}, 32'd1);
        repeat (19) begin @(posedge clk); #1; end
        halted = 1'b1;
        wait_state(0, 3'd4, "run to dump");
        halted = 1'b0;
        pulse_dump_done();
        check("run back to idle", {29'h0, st[0]}, 32'd0);

        // Single steps, with halted already high
        halted = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            dq.push_back(1);
            send_byte(0, 8'h02);
            wait_state(0, 3'd4, "step to dump");
            if (i < 2) begin
                pulse_dump_done();
            end else begin
                @(posedge clk); #1; dump_done = 1'b1; rxv[0] = 1'b1; rxd[0] = 8'h01;
                @(posedge clk); #1; dump_done = 1'b0; rxv[0] = 1'b0;
            end
            check("step back to idle", {29'h0, st[0]}, 32'd0);
        end
        halted = 1'b0;

        // Noise bytes in IDLE and RUN
        send_byte(0, 8'h03);
        send_byte(0, 8'h7F);
        check("noise idle state", {29'h0, st[0]}, 32'd0);
        dq.push_back(5);
        send_byte(0, 8'h04);
        send_byte(0, 8'h01);
        check("noise run state", {29'h0, st[0]}, 32'd2);
        repeat (2) begin @(posedge clk); #1; end
        halted = 1'b1;
        wait_state(0, 3'd4, "noise run to dump");
        halted = 1'b0;
        pulse_dump_done();
        check("noise idle after dump", {29'h0, st[0]}, 32'd0);

        // Overflow with 2-bit address
        send_byte(1, 8'h01);
        for (int unsigned i = 0; i < 4; i++) begin
            wq1.push_back('{i[7:0], 32'hA000_0000 + i});
            send_word(1, 32'hA000_0000 + i);
        end
        repeat (3) @(posedge clk);
        #1;
        check("overflow err", {31'h0, err[1]}, 32'd1);
        check("overflow state", {29'h0, st[1]}, 32'd0);
        check("overflow addr", {24'h0, addr[1]}, 32'd0);
        send_byte(1, 8'h01);
        check("err cleared by load", {31'h0, err[1]}, 32'd0);

        // Reset in the middle of a load
        send_byte(0, 8'h01);
        send_byte(0, 8'h20);
        send_byte(0, 8'h01);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check_reset_outputs(0);
        check("rst dut1 state", {29'h0, st[1]}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wq0.push_back('{8'd0, 32'h0000_0001});
        wq0.push_back('{8'd1, 32'h1234_5678});
        wq0.push_back('{8'd2, 32'hFFFF_FFFF});
        send_byte(0, 8'h01);
        send_stream3(32'h0000_0001, 32'h1234_5678, 32'hFFFF_FFFF);
        repeat (4) @(posedge clk);
        #1;
        check("stream done state", {29'h0, st[0]}, 32'd0);
        check("stream done addr", {24'h0, addr[0]}, 32'h0);

        check("dut0 writes pending", wq0.size(), 32'd0);
        check("dut1 writes pending", wq1.size(), 32'd0);
        check("dumps pending", dq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
